// File: rtl/mic1_microsequencer_pkg.sv
// Shared Mic-1 sequencer definitions: microinstruction layout, register codes, next-address rule.
// Imported by the interface, the control store wrapper and the sequencer top.
package mic1_microsequencer_pkg;

  localparam int MPC_W    = 9;
  localparam int MIR_W    = 36;
  localparam int CS_DEPTH = 1 << MPC_W;

  // Field order matches MIR bit 35 down to bit 0.
  typedef struct packed {
    logic [8:0] next_addr;
    logic       jmpc;
    logic       jamn;
    logic       jamz;
    logic [7:0] alu;
    logic [8:0] c;
    logic       mem_write;
    logic       mem_read;
    logic       mem_fetch;
    logic [3:0] b;
  } mir_t;

  localparam mir_t MIR_NOP = '0;

  typedef enum logic [3:0] {
    C_MAR = 4'd0, C_MDR = 4'd1, C_PC = 4'd2, C_SP  = 4'd3, C_LV = 4'd4,
    C_CPP = 4'd5, C_TOS = 4'd6, C_OPC = 4'd7, C_H  = 4'd8
  } c_bit_e;

  typedef enum logic [3:0] {
    B_MDR = 4'd0, B_PC  = 4'd1, B_MBR = 4'd2, B_MBRU = 4'd3, B_SP = 4'd4,
    B_LV  = 4'd5, B_CPP = 4'd6, B_TOS = 4'd7, B_OPC  = 4'd8
  } b_src_e;

  typedef enum logic [2:0] {
    ALU_INC = 3'd0, ALU_INVA = 3'd1, ALU_ENB = 3'd2, ALU_ENA = 3'd3,
    ALU_F1  = 3'd4, ALU_F0   = 3'd5, ALU_SRA1 = 3'd6, ALU_SLL8 = 3'd7
  } alu_bit_e;

  // JMPC merges the MBR byte by plain OR: no carry into bit 8.
  function automatic logic [MPC_W-1:0] calc_next_mpc(input mir_t mir, input logic n,
                                                     input logic z, input logic [7:0] mbr);
    logic [MPC_W-1:0] nxt;
    nxt[8]   = mir.next_addr[8] | (mir.jamn & n) | (mir.jamz & z);
    nxt[7:0] = mir.jmpc ? (mir.next_addr[7:0] | mbr) : mir.next_addr[7:0];
    return nxt;
  endfunction

endpackage

// File: rtl/mic1_microsequencer_if.sv
// Sequencer <-> datapath/loader bundle: status in, control strobes and debug state out.
interface mic1_microsequencer_if;
  import mic1_microsequencer_pkg::*;

  logic             alu_n;
  logic             alu_z;
  logic [7:0]       mbr_byte;
  logic             stall;
  logic             cs_we;
  logic [MPC_W-1:0] cs_waddr;
  logic [MIR_W-1:0] cs_wdata;
  logic [8:0]       c_select;
  logic [3:0]       b_select_encoded;
  logic [7:0]       alu_ctrl;
  logic             mem_write;
  logic             mem_read;
  logic             mem_fetch;
  logic [MPC_W-1:0] mpc;
  logic             n_flag;
  logic             z_flag;

  modport master (
    input  alu_n, alu_z, mbr_byte, stall, cs_we, cs_waddr, cs_wdata,
    output c_select, b_select_encoded, alu_ctrl, mem_write, mem_read, mem_fetch,
           mpc, n_flag, z_flag
  );

  modport slave (
    output alu_n, alu_z, mbr_byte, stall, cs_we, cs_waddr, cs_wdata,
    input  c_select, b_select_encoded, alu_ctrl, mem_write, mem_read, mem_fetch,
           mpc, n_flag, z_flag
  );

endinterface

// File: rtl/mic1_microsequencer_control_store.sv
// Writable control store: one write port, one registered read-first read port (the MIR).
// rd_clr loads CLR_VAL; rd_en low holds the read register.
module mic1_microsequencer_control_store #(
  parameter int             DEPTH   = 512,
  parameter int             AW      = 9,
  parameter int             DW      = 36,
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_clr)     rd_data <= CLR_VAL;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mic1_microsequencer.sv
// Mic-1 microsequencer: MPC/MIR/flag registers, next-address logic, strobe masking; one uop per cycle.
// Target reaches MIR one cycle after the branch decision; stall freezes state and gates C/MEM strobes.
module mic1_microsequencer
  import mic1_microsequencer_pkg::*;
#(
  parameter logic [MPC_W-1:0] RESET_MPC = '0
) (
  input logic                  clock,
  input logic                  reset,
  mic1_microsequencer_if.master bus
);

  logic [MPC_W-1:0] mpc_q;
  logic [MPC_W-1:0] next_mpc;
  logic [MIR_W-1:0] mir_word;
  mir_t             mir;
  logic             n_q;
  logic             z_q;
  logic             advance;

  assign mir      = mir_word;
  assign advance  = reset && !bus.stall;
  assign next_mpc = calc_next_mpc(mir, bus.alu_n, bus.alu_z, bus.mbr_byte);

  always_ff @(posedge clock) begin
    if (!reset) begin
      mpc_q <= RESET_MPC;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
    end else if (!bus.stall) begin
      mpc_q <= next_mpc;
      n_q   <= bus.alu_n;
      z_q   <= bus.alu_z;
    end
  end

  mic1_microsequencer_control_store #(
    .DEPTH   (CS_DEPTH),
    .AW      (MPC_W),
    .DW      (MIR_W),
    .CLR_VAL (MIR_NOP)
  ) u_cs (
    .clock   (clock),
    .wr_en   (bus.cs_we),
    .wr_addr (bus.cs_waddr),
    .wr_data (bus.cs_wdata),
    .rd_en   (advance),
    .rd_clr  (!reset),
    .rd_addr (next_mpc),
    .rd_data (mir_word)
  );

  // Side-effecting strobes are gated while memory is busy; selects stay visible.
  assign bus.c_select         = bus.stall ? 9'd0 : mir.c;
  assign bus.mem_write        = !bus.stall && mir.mem_write;
  assign bus.mem_read         = !bus.stall && mir.mem_read;
  assign bus.mem_fetch        = !bus.stall && mir.mem_fetch;
  assign bus.b_select_encoded = mir.b;
  assign bus.alu_ctrl         = mir.alu;
  assign bus.mpc              = mpc_q;
  assign bus.n_flag           = n_q;
  assign bus.z_flag           = z_q;

endmodule
